seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised multi-digit hexadecimal 7-segment display driver: latches an N-digit hex value with per-digit decimal points, decodes each nibble to the team's segment encoding, and time-multiplexes digits onto one shared segment bus with a one-hot digit select. It sits between datapath and board pins, replacing per-digit static decoders once digit count exceeds available pins. It adds tear-free frame-synchronous update, leading-zero suppression, per-digit enable and selectable output polarity.

## Interface
- NUM_DIGITS, 8, number of digits scanned (1..16)
- PRESCALE, 1000, clk cycles each digit is held (>=2)
- ACTIVE_LOW, 0, 1 inverts seg and an at the pins
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  hex digits, digit i = value[4i+3:4i], digit 0 least significant
- dp_in  in  NUM_DIGITS  decimal point request per digit
- load  in  1  one-cycle strobe, captures value/dp_in
- digit_en  in  NUM_DIGITS  digit i scanned only when set (live, not latched)
- lz_blank  in  1  enable leading-zero suppression (live)
- seg  out  8  segments {a,b,c,d,e,f,g,dp}, bit 7 = a, bit 0 = dp, logical 1 = lit
- an  out  NUM_DIGITS  one-hot digit select, logical 1 = digit driven
- frame_start  out  1  one-cycle pulse when digit 0 begins

## Operation
- Glyphs (logical, bit7..0): 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 A=EE b=3E C=9C d=7A E=9E F=8E; blank = 00; dp ORs bit 0.
- Registers: prescale counter pc, digit index idx, pending value/dp + pend_valid, shadow value/dp (displayed).
- load=1: pending <= value/dp_in, pend_valid <= 1; later load before frame boundary overwrites pending (last wins).
- Frame boundary = cycle where pc==PRESCALE-1 and idx==NUM_DIGITS-1. At it: shadow <= pending if pend_valid, pend_valid <= 0. If load is high that same cycle, the loaded value goes straight to shadow (bypass), pend_valid <= 0.
- pc counts 0..PRESCALE-1, wraps to 0; at terminal count idx increments, NUM_DIGITS-1 wraps to 0.
- Leading-zero suppression (lz_blank=1): digit i blanked when its shadow nibble and all nibbles above it are 0, except digit 0 never blanked. Blanked digit still shows dp if its dp bit set.
- digit_en[idx]=0: an all inactive, seg = blank for that slot; slot time still consumed, scan order unchanged.
- Physical outputs = logical XOR {ACTIVE_LOW}.

## Timing
- Reset: pc=0, idx=0, pend_valid=0, shadow=0, dp shadow=0; seg=blank, an=all inactive (all ones at pins when ACTIVE_LOW), frame_start=0.
- seg/an/frame_start registered: reflect idx one cycle after idx changes; first digit-0 drive appears cycle 1 after rst deasserts.
- Each digit driven exactly PRESCALE cycles; frame period NUM_DIGITS*PRESCALE cycles.
- frame_start asserted for the one cycle an first selects digit 0 of each frame, including first after reset.
- Display latency from load: shadow changes at next frame boundary; new digit 0 visible one cycle later. Worst case NUM_DIGITS*PRESCALE+1 cycles.
- rst mid-frame: everything returns to reset state next edge; pending load discarded.
- an never has more than one bit active; no glitch between digits (registered, single transition cycle).

## Structure
- Package seg7_pkg: glyph constants SEG_0..SEG_F, SEG_BLANK, SEG_DP_BIT, function hex_to_seg(nibble).
- Sub-module seg7_hex_decode (combinational nibble -> 8-bit glyph), reusable by static-display blocks.
- pc width $clog2(PRESCALE); idx width $clog2(NUM_DIGITS) with minimum 1.

## Test plan
- NUM_DIGITS=4, PRESCALE=4, reset then idle -> an cycles 0001,0010,0100,1000 each 4 cycles, seg=00 all slots, frame_start every 16 cycles.
- load value=16'h12AF, dp_in=4'b0100 mid-frame -> old display until boundary; then digit0 seg=8E, digit1 EE, digit2 DB, digit3 60.
- lz_blank=1, value=16'h0030 -> digits 3,2 seg=00, digit1 F2, digit0 FC; value=0 -> only digit0 shows FC.
- Two loads (16'h1111 then 16'h2222) in one frame, plus load coincident with boundary (16'h3333) -> display shows 3333 next frame, 1111 never shown.
- digit_en=4'b1010 -> an active only in slots 1 and 3, seg=00 in slots 0,2, frame period still 16.
- ACTIVE_LOW=1, rst asserted mid-frame -> next cycle an=1111, seg=FF, pending discarded; display restarts at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph set {a,b,c,d,e,f,g,dp} (bit 7 = a, logical 1 = lit)
// and the nibble-to-glyph lookup used by scanned and static displays.
package seg7_pkg;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_A     = 8'hEE;
    localparam logic [7:0] SEG_B     = 8'h3E;
    localparam logic [7:0] SEG_C     = 8'h9C;
    localparam logic [7:0] SEG_D     = 8'h7A;
    localparam logic [7:0] SEG_E     = 8'h9E;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam int unsigned SEG_DP_BIT = 0;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        logic [7:0] glyph;
        case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to logical 7-segment glyph (dp bit always clear).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex display driver with frame-synchronous update,
// leading-zero suppression, per-digit enable and selectable pin polarity.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned PRESCALE   = 1000,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PC_LAST  = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         pc;
    logic [IW-1:0]         idx;
    logic [VW-1:0]         pend_val;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pend_valid;
    logic [VW-1:0]         shadow_val;
    logic [NUM_DIGITS-1:0] shadow_dp;

    logic [7:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  fs_q;

    logic                  pc_last;
    logic                  boundary;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_en;
    logic                  upper_zero;
    logic [NUM_DIGITS-1:0] sel;
    logic [7:0]            glyph;
    logic [7:0]            seg_d;
    logic [NUM_DIGITS-1:0] an_d;

    assign pc_last  = (pc == PC_LAST);
    assign boundary = pc_last && (idx == IDX_LAST);

    // upper_zero: current digit and every more-significant digit are zero
    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        upper_zero = 1'b1;
        sel        = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (k == 32'(idx)) begin
                cur_nib = shadow_val[4*k +: 4];
                cur_dp  = shadow_dp[k];
                cur_en  = digit_en[k];
                sel[k]  = 1'b1;
            end
            if ((k >= 32'(idx)) && (shadow_val[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (cur_nib),
        .seg    (glyph)
    );

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '0;
        if (cur_en) begin
            an_d = sel;
            if (!(lz_blank && upper_zero && (idx != '0))) begin
                seg_d = glyph;
            end
            seg_d[SEG_DP_BIT] = seg_d[SEG_DP_BIT] | cur_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= '0;
            fs_q       <= 1'b0;
        end else begin
            pc <= pc_last ? '0 : pc + 1'b1;
            if (pc_last) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            // A load on the boundary cycle bypasses pending straight to shadow.
            if (boundary) begin
                if (load) begin
                    shadow_val <= value;
                    shadow_dp  <= dp_in;
                end else if (pend_valid) begin
                    shadow_val <= pend_val;
                    shadow_dp  <= pend_dp;
                end
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end

            seg_q <= seg_d;
            an_q  <= an_d;
            fs_q  <= (pc == '0) && (idx == '0);
        end
    end

    assign seg         = seg_q ^ {8{ACTIVE_LOW}};
    assign an          = an_q ^ {NUM_DIGITS{ACTIVE_LOW}};
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: 4 digits, prescale 4, active-high and
// active-low instances driven in parallel and checked every cycle.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int FR = N * P;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      = 1'b1;
    logic [15:0] value    = '0;
    logic [3:0]  dp_in    = '0;
    logic        load     = 1'b0;
    logic [3:0]  digit_en = 4'hF;
    logic        lz_blank = 1'b0;

    logic [7:0] seg_h, seg_l;
    logic [3:0] an_h, an_l;
    logic       fs_h, fs_l;

    seg7_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .digit_en(digit_en), .lz_blank(lz_blank),
        .seg(seg_h), .an(an_h), .frame_start(fs_h)
    );

    seg7_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .digit_en(digit_en), .lz_blank(lz_blank),
        .seg(seg_l), .an(an_l), .frame_start(fs_l)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference glyph table and display model
    logic [7:0] GL [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                            8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    int          n_edges = 0;
    logic [15:0] m_sh    = '0;
    logic [15:0] m_pend  = '0;
    logic [3:0]  m_dsh   = '0;
    logic [3:0]  m_dpend = '0;
    bit          m_pv    = 1'b0;

    always @(posedge clk) begin
        int         slot;
        bit         nz;
        logic [7:0] e_seg, e_seg_l;
        logic [3:0] e_an, e_an_l;
        logic       e_fs;
        if (rst) begin
            e_seg = 8'h00; e_an = 4'h0; e_fs = 1'b0;
            n_edges = 0; m_sh = '0; m_pend = '0; m_dsh = '0; m_dpend = '0; m_pv = 1'b0;
        end else begin
            slot = (n_edges / P) % N;
            e_fs = ((n_edges % FR) == 0);
            nz = 1'b0;
            for (int k = slot; k < N; k++) if (m_sh[4*k +: 4] != 4'h0) nz = 1'b1;
            if (lz_blank && !nz && slot != 0) e_seg = 8'h00;
            else e_seg = GL[m_sh[4*slot +: 4]];
            if (m_dsh[slot]) e_seg = e_seg | 8'h01;
            e_an = 4'h0;
            if (digit_en[slot]) e_an[slot] = 1'b1;
            else e_seg = 8'h00;
            if ((n_edges % FR) == FR - 1) begin
                if (load) begin m_sh = value; m_dsh = dp_in; end
                else if (m_pv) begin m_sh = m_pend; m_dsh = m_dpend; end
                m_pv = 1'b0;
            end else if (load) begin
                m_pend = value; m_dpend = dp_in; m_pv = 1'b1;
            end
            n_edges++;
        end
        e_seg_l = ~e_seg;
        e_an_l  = ~e_an;
        #1;
        chk("seg", seg_h, e_seg);
        chk("seg_al", seg_l, e_seg_l);
        chk("an", an_h, e_an);
        chk("an_al", an_l, e_an_l);
        chk("fs", fs_h, e_fs);
        chk("fs_al", fs_l, e_fs);
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_fs(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (fs_h !== 1'b1 && c < 40);
        if (fs_h !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_fs: frame_start not seen within %0d cycles", c);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    // Called at a frame_start cycle; checks the glyph of digits 0..3 in turn
    task automatic check_frame(input string tag, input logic [31:0] exp);
        for (int d = 0; d < N; d++) begin
            chk(tag, seg_h, exp[8*d +: 8]);
            if (d < N - 1) step(P);
        end
    endtask

    initial begin
        int c;
        step(3);
        chk("rst_seg", seg_h, 8'h00);
        chk("rst_seg_al", seg_l, 8'hFF);
        chk("rst_an_al", an_l, 4'hF);
        chk("rst_fs", fs_h, 1'b0);
        rst = 1'b0;

        step(1);
        chk("first_fs", fs_h, 1'b1);
        chk("first_an", an_h, 4'b0001);
        step(P); chk("idle_an1", an_h, 4'b0010);
        step(P); chk("idle_an2", an_h, 4'b0100);
        step(P); chk("idle_an3", an_h, 4'b1000);
        wait_fs(c);
        wait_fs(c);
        chk("period", c, FR);

        step(5);
        pulse_load(16'h12AF, 4'b0100);
        wait_fs(c);
        check_frame("load12AF", {8'h60, 8'hDB, 8'hEE, 8'h8E});

        lz_blank = 1'b1;
        pulse_load(16'h0030, 4'b0000);
        wait_fs(c);
        check_frame("lz0030", {8'h00, 8'h00, 8'hF2, 8'hFC});
        pulse_load(16'h0000, 4'b0000);
        wait_fs(c);
        check_frame("lz0000", {8'h00, 8'h00, 8'h00, 8'hFC});
        lz_blank = 1'b0;

        wait_fs(c);
        step(2);
        pulse_load(16'h1111, 4'b0000);
        step(2);
        pulse_load(16'h2222, 4'b0000);
        step(8);
        pulse_load(16'h3333, 4'b0000);
        step(1);
        chk("boundary_fs", fs_h, 1'b1);
        check_frame("bypass3333", {8'hF2, 8'hF2, 8'hF2, 8'hF2});

        digit_en = 4'b1010;
        wait_fs(c);
        chk("en_an0", an_h, 4'b0000); chk("en_seg0", seg_h, 8'h00);
        step(P);
        chk("en_an1", an_h, 4'b0010); chk("en_seg1", seg_h, 8'hF2);
        step(P);
        chk("en_an2", an_h, 4'b0000); chk("en_seg2", seg_h, 8'h00);
        step(P);
        chk("en_an3", an_h, 4'b1000); chk("en_seg3", seg_h, 8'hF2);
        wait_fs(c);
        wait_fs(c);
        chk("en_period", c, FR);

        digit_en = 4'hF;
        step(5);
        pulse_load(16'h4444, 4'b0000);
        step(1);
        rst = 1'b1;
        step(1);
        chk("midrst_an_al", an_l, 4'hF);
        chk("midrst_seg_al", seg_l, 8'hFF);
        chk("midrst_an", an_h, 4'h0);
        rst = 1'b0;
        step(1);
        chk("restart_fs", fs_h, 1'b1);
        chk("restart_an", an_h, 4'b0001);
        chk("restart_seg", seg_h, 8'hFC);
        wait_fs(c);
        chk("restart_period", c, FR);
        check_frame("after_rst", {8'hFC, 8'hFC, 8'hFC, 8'hFC});

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
